// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave core: FSM states, FIFO word geometry
// and the R/W direction bit values.
package i2c_pkg;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic DIR_R = 1'b1;
  localparam logic DIR_W = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus a delayed copy for edge
// detection.
//   CLK_I, RST_I (async, active-high), srst (sync) : clock / resets
//   d_i    : raw asynchronous input
//   q_o    : synchronised level
//   rise_o : one-cycle pulse on a synchronised 0->1 transition
//   fall_o : one-cycle pulse on a synchronised 1->0 transition
module i2c_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic srst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] first sync flop, [1] second sync flop, [2] delayed copy
  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d_i};
    if (srst) begin
      sh_d = {3{RST_VAL}};
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sh_q <= {3{RST_VAL}};
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_o    = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave link layer between the bus pins and 32-bit RX/TX word FIFOs.
//   CLK_I, RST_I (async, active-high), srst (sync soft reset)
//   scl_i, sda_i : raw bus pins;  sda_oe : 1 pulls SDA low
//   reg_addr     : own 7-bit address
//   RX FIFO      : full in, push/dout out
//   TX FIFO      : empty/din in (first-word-fall-through), pop out
//   wstop/rstop/rerr : end-of-transaction pulses
//   addr_r, byte_buf, byte_done : per-transaction / per-byte taps
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter int unsigned WORD_BYTES = i2c_pkg::WORD_BYTES
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        srst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [6:0]  reg_addr,
  input  logic        full,
  output logic        push,
  output logic [31:0] dout,
  input  logic        empty,
  output logic        pop,
  input  logic [31:0] din,
  output logic        wstop,
  output logic        rstop,
  output logic        rerr,
  output logic [6:0]  addr_r,
  output logic [7:0]  byte_buf,
  output logic        byte_done
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_scl (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .srst   (srst),
    .d_i    (scl_i),
    .q_o    (scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.RST_VAL(1'b1)) u_sync_sda (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .srst   (srst),
    .d_i    (sda_i),
    .q_o    (sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] word_q, word_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  byte_buf_q, byte_buf_d;
  logic        rw_q, rw_d;
  logic        act_q, act_d;
  logic        pushed_q, pushed_d;
  logic        nack_ok_q, nack_ok_d;
  logic        rd_err_q, rd_err_d;
  logic        sda_oe_q, sda_oe_d;
  logic        push_q, push_d;
  logic        pop_q, pop_d;
  logic        byte_done_q, byte_done_d;
  logic        wstop_q, wstop_d;
  logic        rstop_q, rstop_d;
  logic        rerr_q, rerr_d;

  logic [7:0]  rx_byte;
  logic [4:0]  byte_idx;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    word_d      = word_q;
    addr_d      = addr_q;
    byte_buf_d  = byte_buf_q;
    rw_d        = rw_q;
    act_d       = act_q;
    pushed_d    = pushed_q;
    nack_ok_d   = nack_ok_q;
    rd_err_d    = rd_err_q;
    sda_oe_d    = sda_oe_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    byte_done_d = 1'b0;
    wstop_d     = 1'b0;
    rstop_d     = 1'b0;
    rerr_d      = 1'b0;
    rx_byte     = {shift_q, sda};
    byte_idx    = {LAST_BYTE - byte_cnt_q, 3'b000};

    if (start_det) begin
      state_d    = ST_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      act_d      = 1'b0;
      pushed_d   = 1'b0;
      nack_ok_d  = 1'b0;
      rd_err_d   = 1'b0;
      sda_oe_d   = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      sda_oe_d   = 1'b0;
      act_d      = 1'b0;
      if (act_q) begin
        if (rw_q == DIR_W) begin
          wstop_d = pushed_q && (byte_cnt_q == '0);
        end else if (nack_ok_q) begin
          rstop_d = 1'b1;
        end else begin
          rerr_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        ST_IDLE, ST_IGNORE: begin
        end

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              addr_d    = shift_q;
              rw_d      = sda;
              if (shift_q != reg_addr) begin
                state_d = ST_IGNORE;
              end else if ((sda == DIR_W) && full) begin
                state_d = ST_IGNORE;
              end else if ((sda == DIR_R) && empty) begin
                rerr_d  = 1'b1;
                state_d = ST_IGNORE;
              end else begin
                act_d   = 1'b1;
                state_d = ST_ADDR_ACK;
              end
            end
          end
        end

        // sda_oe_q separates the fall that starts the ACK clock from the
        // fall that ends it.
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (rw_q == DIR_R) begin
                tx_d  = din;
                pop_d = ~empty;
              end
            end else begin
              bit_cnt_d = '0;
              if (rw_q == DIR_R) begin
                sda_oe_d = ~tx_q[31];
                tx_d     = {tx_q[30:0], 1'b0};
                state_d  = ST_RD_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WR_BYTE;
              end
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d            = '0;
              byte_buf_d           = rx_byte;
              byte_done_d          = 1'b1;
              word_d[byte_idx +: 8] = rx_byte;
              state_d              = ST_WR_ACK;
              if (byte_cnt_q == LAST_BYTE) begin
                push_d     = 1'b1;
                pushed_d   = 1'b1;
                byte_cnt_d = '0;
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_BYTE;
            end
          end
        end

        ST_RD_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~tx_q[31];
            tx_d     = {tx_q[30:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda) begin
              state_d = ST_RD_BYTE;
              if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                if (!empty) begin
                  pop_d = 1'b1;
                  tx_d  = din;
                end else begin
                  tx_d     = '1;
                  rd_err_d = 1'b1;
                end
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end else begin
              nack_ok_d = (byte_cnt_q == LAST_BYTE) && !rd_err_q;
              state_d   = ST_IGNORE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      byte_buf_q  <= '0;
      rw_q        <= 1'b0;
      act_q       <= 1'b0;
      pushed_q    <= 1'b0;
      nack_ok_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      byte_done_q <= 1'b0;
      wstop_q     <= 1'b0;
      rstop_q     <= 1'b0;
      rerr_q      <= 1'b0;
    end else if (srst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      byte_buf_q  <= '0;
      rw_q        <= 1'b0;
      act_q       <= 1'b0;
      pushed_q    <= 1'b0;
      nack_ok_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      byte_done_q <= 1'b0;
      wstop_q     <= 1'b0;
      rstop_q     <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      byte_buf_q  <= byte_buf_d;
      rw_q        <= rw_d;
      act_q       <= act_d;
      pushed_q    <= pushed_d;
      nack_ok_q   <= nack_ok_d;
      rd_err_q    <= rd_err_d;
      sda_oe_q    <= sda_oe_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      byte_done_q <= byte_done_d;
      wstop_q     <= wstop_d;
      rstop_q     <= rstop_d;
      rerr_q      <= rerr_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign push      = push_q;
  assign dout      = word_q;
  assign pop       = pop_q;
  assign wstop     = wstop_q;
  assign rstop     = rstop_q;
  assign rerr      = rerr_q;
  assign addr_r    = addr_q;
  assign byte_buf  = byte_buf_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
`timescale 1ns/1ps
module tb_i2c_slave_core;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        srst  = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        full  = 1'b0;
  logic        empty = 1'b0;
  logic [6:0]  reg_addr = 7'h40;
  logic [31:0] din = '0;

  logic        scl_i, sda_i, sda_oe, push, pop, wstop, rstop, rerr, byte_done;
  logic [31:0] dout;
  logic [6:0]  addr_r;
  logic [7:0]  byte_buf;

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  i2c_slave_core #(.WORD_BYTES(4)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .srst      (srst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .full      (full),
    .push      (push),
    .dout      (dout),
    .empty     (empty),
    .pop       (pop),
    .din       (din),
    .wstop     (wstop),
    .rstop     (rstop),
    .rerr      (rerr),
    .addr_r    (addr_r),
    .byte_buf  (byte_buf),
    .byte_done (byte_done)
  );

  always #5 CLK_I = ~CLK_I;

  localparam int Q = 100;  // quarter SCL period, 10 CLK_I cycles

  int tests_run    = 0;
  int tests_failed = 0;

  int n_push = 0, n_pop = 0, n_pop_bad = 0, n_wstop = 0, n_rstop = 0, n_rerr = 0, n_bd = 0;
  logic [31:0] words[$];

  always @(negedge CLK_I) begin
    if (push) begin
      n_push++;
      words.push_back(dout);
    end
    if (pop) n_pop++;
    if (pop && empty) n_pop_bad++;
    if (wstop) n_wstop++;
    if (rstop) n_rstop++;
    if (rerr) n_rerr++;
    if (byte_done) n_bd++;
  end

  logic [7:0] wdata [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic wr_bit(input logic b);
    m_sda = b; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic rd_bit(output logic b);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    b = sda_i; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(a);
    ack = ~a;
  endtask

  task automatic rd_byte(output logic [7:0] v, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(~ack);
  endtask

  task automatic settle();
    repeat (20) @(negedge CLK_I);
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    tests_run++;
    if ({sda_oe, push, pop, wstop, rstop, rerr, byte_done} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b, expected 0000000",
               {sda_oe, push, pop, wstop, rstop, rerr, byte_done});
    end
    tests_run++;
    if ({dout, addr_r, byte_buf} !== 47'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: dout=%h addr_r=%h byte_buf=%h, expected all 0", dout, addr_r, byte_buf);
    end
    RST_I = 1'b0;
    repeat (5) @(negedge CLK_I);
  endtask

  task automatic test_full_write(input string tag);
    int b_push = n_push, b_wstop = n_wstop, b_bd = n_bd, b_r = n_rstop + n_rerr;
    int w0 = words.size();
    int acks = 0;
    logic ack;
    i2c_start();
    wr_byte(8'h80, ack);
    if (ack) acks++;
    for (int i = 0; i < 8; i++) begin
      wr_byte(wdata[i], ack);
      if (ack) acks++;
    end
    i2c_stop();
    settle();
    tests_run++;
    if (acks !== 9) begin
      tests_failed++;
      $display("FAIL %s_acks: got %0d, expected 9", tag, acks);
    end
    tests_run++;
    if (n_push - b_push !== 2) begin
      tests_failed++;
      $display("FAIL %s_push_count: got %0d, expected 2", tag, n_push - b_push);
    end
    tests_run++;
    if (words.size() < w0 + 2) begin
      tests_failed++;
      $display("FAIL %s_dout: only %0d words pushed, expected 2", tag, words.size() - w0);
    end else if (words[w0] !== 32'h11223344 || words[w0+1] !== 32'h55667788) begin
      tests_failed++;
      $display("FAIL %s_dout: got %h %h, expected 11223344 55667788", tag, words[w0], words[w0+1]);
    end
    tests_run++;
    if (n_wstop - b_wstop !== 1) begin
      tests_failed++;
      $display("FAIL %s_wstop: got %0d, expected 1", tag, n_wstop - b_wstop);
    end
    tests_run++;
    if (n_bd - b_bd !== 8) begin
      tests_failed++;
      $display("FAIL %s_byte_done: got %0d, expected 8", tag, n_bd - b_bd);
    end
    tests_run++;
    if (byte_buf !== 8'h88 || addr_r !== 7'h40) begin
      tests_failed++;
      $display("FAIL %s_taps: byte_buf=%h addr_r=%h, expected 88 40", tag, byte_buf, addr_r);
    end
    tests_run++;
    if (n_rstop + n_rerr - b_r !== 0) begin
      tests_failed++;
      $display("FAIL %s_read_pulses: got %0d, expected 0", tag, n_rstop + n_rerr - b_r);
    end
  endtask

  task automatic test_read_word();
    int b_pop = n_pop, b_rstop = n_rstop, b_rerr = n_rerr, b_push = n_push;
    logic ack;
    logic [7:0] b0, b1, b2, b3;
    din = 32'hA5C3_0F01;
    empty = 1'b0;
    i2c_start();
    wr_byte(8'h81, ack);
    rd_byte(b0, 1'b1);
    rd_byte(b1, 1'b1);
    rd_byte(b2, 1'b1);
    rd_byte(b3, 1'b0);
    i2c_stop();
    settle();
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_addr_ack: got %b, expected 1", ack);
    end
    tests_run++;
    if ({b0, b1, b2, b3} !== 32'hA5C30F01) begin
      tests_failed++;
      $display("FAIL read_data: got %h, expected a5c30f01", {b0, b1, b2, b3});
    end
    tests_run++;
    if (n_pop - b_pop !== 1) begin
      tests_failed++;
      $display("FAIL read_pop: got %0d, expected 1", n_pop - b_pop);
    end
    tests_run++;
    if (n_rstop - b_rstop !== 1 || n_rerr - b_rerr !== 0) begin
      tests_failed++;
      $display("FAIL read_end: rstop=%0d rerr=%0d, expected 1 0", n_rstop - b_rstop, n_rerr - b_rerr);
    end
    tests_run++;
    if (n_push - b_push !== 0) begin
      tests_failed++;
      $display("FAIL read_no_push: got %0d, expected 0", n_push - b_push);
    end
  endtask

  task automatic test_read_empty();
    int b_pop = n_pop, b_rerr = n_rerr, b_rstop = n_rstop;
    logic ack;
    empty = 1'b1;
    i2c_start();
    wr_byte(8'h81, ack);
    i2c_stop();
    settle();
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_addr_nack: ack=%b, expected 0", ack);
    end
    tests_run++;
    if (n_rerr - b_rerr !== 1 || n_rstop - b_rstop !== 0) begin
      tests_failed++;
      $display("FAIL empty_rerr: rerr=%0d rstop=%0d, expected 1 0", n_rerr - b_rerr, n_rstop - b_rstop);
    end
    tests_run++;
    if (n_pop - b_pop !== 0 || n_pop_bad !== 0) begin
      tests_failed++;
      $display("FAIL empty_pop: pop=%0d pop_when_empty=%0d, expected 0 0", n_pop - b_pop, n_pop_bad);
    end
    empty = 1'b0;
  endtask

  task automatic test_partial_write();
    int b_push = n_push, b_wstop = n_wstop, b_bd = n_bd;
    int acks = 0;
    logic ack;
    logic [7:0] pd [3] = '{8'hDE, 8'hAD, 8'hBE};
    i2c_start();
    wr_byte(8'h80, ack);
    if (ack) acks++;
    for (int i = 0; i < 3; i++) begin
      wr_byte(pd[i], ack);
      if (ack) acks++;
    end
    i2c_stop();
    settle();
    tests_run++;
    if (n_bd - b_bd !== 3 || acks !== 4) begin
      tests_failed++;
      $display("FAIL partial_bytes: byte_done=%0d acks=%0d, expected 3 4", n_bd - b_bd, acks);
    end
    tests_run++;
    if (n_push - b_push !== 0 || n_wstop - b_wstop !== 0) begin
      tests_failed++;
      $display("FAIL partial_strobes: push=%0d wstop=%0d, expected 0 0", n_push - b_push, n_wstop - b_wstop);
    end
    tests_run++;
    if (byte_buf !== 8'hBE) begin
      tests_failed++;
      $display("FAIL partial_byte_buf: got %h, expected be", byte_buf);
    end
  endtask

  task automatic test_addr_mismatch();
    int b_all = n_push + n_pop + n_bd + n_wstop + n_rstop + n_rerr;
    logic ack1, ack2;
    i2c_start();
    wr_byte(8'h82, ack1);
    tests_run++;
    if (ack1 !== 1'b0 || addr_r !== 7'h41) begin
      tests_failed++;
      $display("FAIL mismatch_nack: ack=%b addr_r=%h, expected 0 41", ack1, addr_r);
    end
    i2c_start();
    wr_byte(8'h80, ack2);
    i2c_stop();
    settle();
    tests_run++;
    if (ack2 !== 1'b1 || addr_r !== 7'h40) begin
      tests_failed++;
      $display("FAIL restart_ack: ack=%b addr_r=%h, expected 1 40", ack2, addr_r);
    end
    tests_run++;
    if (n_push + n_pop + n_bd + n_wstop + n_rstop + n_rerr - b_all !== 0) begin
      tests_failed++;
      $display("FAIL mismatch_strobes: got %0d, expected 0",
               n_push + n_pop + n_bd + n_wstop + n_rstop + n_rerr - b_all);
    end
  endtask

  task automatic test_reset_mid_read();
    logic ack, b;
    din = 32'hA5C3_0F01;
    empty = 1'b0;
    i2c_start();
    wr_byte(8'h81, ack);
    rd_bit(b);
    tests_run++;
    if (b !== 1'b1 || sda_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL midread_drive: bit7=%b sda_oe=%b, expected 1 1", b, sda_oe);
    end
    @(negedge CLK_I);
    #1 RST_I = 1'b1;
    #1;
    tests_run++;
    if (sda_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_oe: got %b, expected 0", sda_oe);
    end
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    test_full_write("after_reset");
  endtask

  initial begin
    test_reset();
    test_full_write("write8");
    test_read_word();
    test_read_empty();
    test_partial_write();
    test_addr_mismatch();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
